// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file instruction sequencer:
// opcode encodings, FSM state encoding and the illegal-opcode test.
package rf_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  // Opcodes above SHR are unassigned.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op > OP_SHR);
  endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer. Results are truncated to DATA_WIDTH;
// carry_o carries the bit shifted or overflowed out (borrow for SUB).
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [3:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  carry_o
);

  logic [DATA_WIDTH:0] sum_ab;
  logic [DATA_WIDTH:0] sum_ai;
  logic [DATA_WIDTH:0] diff_ab;

  assign sum_ab  = {1'b0, a_i} + {1'b0, b_i};
  assign sum_ai  = {1'b0, a_i} + {1'b0, imm_i};
  // The extra top bit of the widened difference is the unsigned borrow.
  assign diff_ab = {1'b0, a_i} - {1'b0, b_i};

  // Operation select
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD:  {carry_o, result_o} = sum_ab;
      OP_SUB:  {carry_o, result_o} = diff_ab;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_LDI:  result_o = imm_i;
      OP_ADDI: {carry_o, result_o} = sum_ai;
      OP_SHL:  {carry_o, result_o} = {a_i, 1'b0};
      OP_SHR: begin
        result_o = {1'b0, a_i[DATA_WIDTH-1:1]};
        carry_o  = a_i[0];
      end
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rf_sequencer.sv
// Serialised instruction sequencer in front of the general-purpose register
// file: accept, read operands, execute, write back; one instruction per four
// cycles, so read-after-write needs no forwarding.
// Optional build macro: RF_SEQ_FLAGS_EN enables the zero/carry flag
// registers; without it flag_z/flag_c are tied low.
//
// state  | meaning
// S_IDLE | waiting for an instruction, instr_ready high
// S_READ | source addresses presented, file samples them
// S_EXEC | operands valid, ALU result captured at exit
// S_WB   | write-back, result_valid (and err) pulse
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_FILE_SIZE = 16,
  parameter int ADDR_WIDTH    = $clog2(REG_FILE_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [ADDR_WIDTH-1:0] rf_addr_a,
  output logic [ADDR_WIDTH-1:0] rf_addr_b,
  input  logic [DATA_WIDTH-1:0] rf_operand_a,
  input  logic [DATA_WIDTH-1:0] rf_operand_b,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_addr_write,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  err,
  output logic                  flag_z,
  output logic                  flag_c
);

  logic [1:0]            state_q, state_d;
  logic [3:0]            op_q;
  logic [ADDR_WIDTH-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic                  accept;
  logic                  op_bad;
  logic                  op_writes;

  assign instr_ready = (state_q == S_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign op_bad      = op_illegal(op_q);
  // NOP and illegal opcodes neither write back nor touch result/flags.
  assign op_writes   = (op_q != OP_NOP) && !op_bad;

  rf_seq_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op_i    (op_q),
    .a_i     (rf_operand_a),
    .b_i     (rf_operand_b),
    .imm_i   (imm_q),
    .result_o(alu_result),
    .carry_o (alu_carry)
  );

  // Next-state logic: only IDLE waits, every other state advances.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, instruction latch and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= opcode;
        rd_q  <= rd;
        rs1_q <= rs1;
        rs2_q <= rs2;
        imm_q <= imm;
      end
      if ((state_q == S_EXEC) && op_writes) begin
        result_q <= alu_result;
      end
    end
  end

  assign rf_addr_a     = (state_q == S_IDLE) ? '0 : rs1_q;
  assign rf_addr_b     = (state_q == S_IDLE) ? '0 : rs2_q;
  assign rf_wen        = (state_q == S_WB) && op_writes;
  assign rf_addr_write = (state_q == S_WB) ? rd_q : '0;
  assign rf_data_in    = result_q;
  assign result        = result_q;
  assign result_valid  = (state_q == S_WB);
  assign err           = (state_q == S_WB) && op_bad;

`ifdef RF_SEQ_FLAGS_EN
  logic flag_z_q, flag_c_q;

  // Flags follow the result register and hold on NOP/illegal.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else if ((state_q == S_EXEC) && op_writes) begin
      flag_z_q <= (alu_result == '0);
      flag_c_q <= alu_carry;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`else
  logic unused_flag_carry;

  assign unused_flag_carry = alu_carry;
  assign flag_z            = 1'b0;
  assign flag_c            = 1'b0;
`endif

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench for rf_sequencer with a behavioural register file
// (synchronous two-port read, one write port, r0 hardwired to zero).
module tb_rf_sequencer;

  localparam int DW = 8;
  localparam int AW = 4;
`ifdef RF_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [3:0]    opcode = '0;
  logic [AW-1:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [DW-1:0] imm = '0;
  logic [AW-1:0] rf_addr_a, rf_addr_b, rf_addr_write;
  logic [DW-1:0] rf_operand_a = '0, rf_operand_b = '0;
  logic          rf_wen;
  logic [DW-1:0] rf_data_in, result;
  logic          result_valid, err, flag_z, flag_c;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] regs [16];

  always #5 clk = ~clk;

  rf_sequencer #(.DATA_WIDTH(DW), .REG_FILE_SIZE(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode       (opcode),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .imm          (imm),
    .rf_addr_a    (rf_addr_a),
    .rf_addr_b    (rf_addr_b),
    .rf_operand_a (rf_operand_a),
    .rf_operand_b (rf_operand_b),
    .rf_wen       (rf_wen),
    .rf_addr_write(rf_addr_write),
    .rf_data_in   (rf_data_in),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .flag_z       (flag_z),
    .flag_c       (flag_c)
  );

  // Register file model
  always @(posedge clk) begin
    rf_operand_a <= regs[rf_addr_a];
    rf_operand_b <= regs[rf_addr_b];
    if (rf_wen && (rf_addr_write != '0)) regs[rf_addr_write] <= rf_data_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [DW-1:0] imm;
    logic          wen;
    logic          er;
    logic [DW-1:0] res;
    logic          z, c;
  } vec_t;

  vec_t vecs [15];

  task automatic run_instr(input vec_t v);
    @(negedge clk);
    check("ready_before", {31'd0, instr_ready}, 32'd1);
    opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 3) begin
        check("busy_ready", {31'd0, instr_ready}, 32'd0);
        check("early_rv", {31'd0, result_valid}, 32'd0);
        check("early_wen", {31'd0, rf_wen}, 32'd0);
        check("addr_a", {28'd0, rf_addr_a}, {28'd0, v.rs1});
        check("addr_b", {28'd0, rf_addr_b}, {28'd0, v.rs2});
      end else if (k == 3) begin
        check("wb_ready", {31'd0, instr_ready}, 32'd0);
        check("wb_rv", {31'd0, result_valid}, 32'd1);
        check("wb_wen", {31'd0, rf_wen}, {31'd0, v.wen});
        check("wb_err", {31'd0, err}, {31'd0, v.er});
        check("wb_result", {24'd0, result}, {24'd0, v.res});
        check("flag_z", {31'd0, flag_z}, {31'd0, FLAGS & v.z});
        check("flag_c", {31'd0, flag_c}, {31'd0, FLAGS & v.c});
        if (v.wen) begin
          check("wb_addr", {28'd0, rf_addr_write}, {28'd0, v.rd});
          check("wb_data", {24'd0, rf_data_in}, {24'd0, v.res});
        end
      end else begin
        check("post_rv", {31'd0, result_valid}, 32'd0);
        check("post_err", {31'd0, err}, 32'd0);
        check("post_ready", {31'd0, instr_ready}, 32'd1);
        check("idle_addr_a", {28'd0, rf_addr_a}, 32'd0);
      end
    end
  endtask

  initial begin
    //          op   rd  rs1 rs2 imm    wen er res    z  c
    vecs[0]  = '{4'd6,  1, 0, 0, 8'h05, 1, 0, 8'h05, 0, 0}; // LDI r1
    vecs[1]  = '{4'd6,  2, 0, 0, 8'hFF, 1, 0, 8'hFF, 0, 0}; // LDI r2
    vecs[2]  = '{4'd1,  3, 1, 2, 8'h00, 1, 0, 8'h04, 0, 1}; // ADD r3=r1+r2
    vecs[3]  = '{4'd2,  4, 1, 1, 8'h00, 1, 0, 8'h00, 1, 0}; // SUB r1-r1
    vecs[4]  = '{4'd2,  6, 1, 2, 8'h00, 1, 0, 8'h06, 0, 1}; // SUB r1-r2
    vecs[5]  = '{4'd12, 7, 1, 2, 8'h00, 0, 1, 8'h06, 0, 1}; // illegal, hold
    vecs[6]  = '{4'd6,  0, 0, 0, 8'h07, 1, 0, 8'h07, 0, 0}; // LDI r0
    vecs[7]  = '{4'd6,  8, 0, 0, 8'h81, 1, 0, 8'h81, 0, 0}; // LDI r8
    vecs[8]  = '{4'd8,  9, 8, 0, 8'h00, 1, 0, 8'h02, 0, 1}; // SHL
    vecs[9]  = '{4'd9, 10, 8, 0, 8'h00, 1, 0, 8'h40, 0, 1}; // SHR
    vecs[10] = '{4'd3, 11, 8, 2, 8'h00, 1, 0, 8'h81, 0, 0}; // AND
    vecs[11] = '{4'd4, 12, 1, 3, 8'h00, 1, 0, 8'h05, 0, 0}; // OR
    vecs[12] = '{4'd5, 13, 2, 8, 8'h00, 1, 0, 8'h7E, 0, 0}; // XOR
    vecs[13] = '{4'd7, 14, 1, 0, 8'hFC, 1, 0, 8'h01, 0, 1}; // ADDI
    vecs[14] = '{4'd0, 15, 1, 2, 8'h00, 0, 0, 8'h01, 0, 1}; // NOP, hold

    for (int i = 0; i < 16; i++) regs[i] = '0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_rv", {31'd0, result_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
    check("rst_addr", {24'd0, rf_addr_a, rf_addr_b}, 32'd0);

    for (int i = 0; i < 15; i++) run_instr(vecs[i]);

    check("reg_r0", {24'd0, regs[0]}, 32'h00);
    check("reg_r3", {24'd0, regs[3]}, 32'h04);
    check("reg_r6", {24'd0, regs[6]}, 32'h06);
    check("reg_r7", {24'd0, regs[7]}, 32'h00);
    check("reg_r13", {24'd0, regs[13]}, 32'h7E);
    check("reg_r15", {24'd0, regs[15]}, 32'h00);

    // Reset while ADD r5=r1+r2 is in EXEC.
    @(negedge clk);
    opcode = 4'd1; rd = 4'd5; rs1 = 4'd1; rs2 = 4'd2; imm = '0;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("mid_rst_result", {24'd0, result}, 32'd0);
    check("mid_rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
    check("mid_rst_addr", {28'd0, rf_addr_a}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("mid_rst_wen", {31'd0, rf_wen}, 32'd0);
      check("mid_rst_rv", {31'd0, result_valid}, 32'd0);
      @(negedge clk);
    end
    check("reg_r5_kept", {24'd0, regs[5]}, 32'h00);

    run_instr('{4'd6, 5, 0, 0, 8'h33, 1, 0, 8'h33, 0, 0});
    check("reg_r5_new", {24'd0, regs[5]}, 32'h33);

    // Held instr_valid: the next instruction must not be taken until after WB.
    @(negedge clk);
    opcode = 4'd7; rd = 4'd6; rs1 = 4'd5; rs2 = 4'd0; imm = 8'h01;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 opcode = 4'd6; rd = 4'd7; imm = 8'h99;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("hold_ready", {31'd0, instr_ready}, 32'd0);
    end
    check("hold_wb_data", {24'd0, rf_data_in}, 32'h34);
    @(negedge clk);
    check("hold_ready_up", {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_second_rv", {31'd0, result_valid}, 32'd1);
    check("hold_second_data", {24'd0, rf_data_in}, 32'h99);
    @(negedge clk);
    check("reg_r6_new", {24'd0, regs[6]}, 32'h34);
    check("reg_r7_new", {24'd0, regs[7]}, 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
